// File: rtl/wave_xlat_pkg.sv
// Shared types and width helpers for the multichannel sample-to-pixel address translator.
// Holds the FSM state encoding, the 16-bit offset-binary width and clog2-based width derivation.
package wave_xlat_pkg;

  localparam int OFFSET_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    CALC,
    OUT
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Counter/field width for a count of items; never collapses to zero bits.
  function automatic int width_of(input int count);
    return (count < 2) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/sample_to_row_scaler.sv
// Combinational map of a signed sample to a row inside one channel lane (0 = full-scale positive).
// Zero latency, no handshake; only the top OFFSET_BITS of the sample contribute.
module sample_to_row_scaler
  import wave_xlat_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LANE_HEIGHT = 240,
  parameter int ROW_W       = 8
) (
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [ROW_W-1:0]      row
);

  localparam int LH_W   = clog2(LANE_HEIGHT + 1);
  localparam int PROD_W = OFFSET_BITS + LH_W;

  logic [OFFSET_BITS-1:0] u;
  logic [PROD_W-1:0]      prod;
  logic [LH_W-1:0]        scaled;

  // Flipping the sign bit turns two's complement into offset binary.
  assign u      = {~sample[DATA_WIDTH-1], sample[DATA_WIDTH-2 -: OFFSET_BITS-1]};
  assign prod   = PROD_W'(u) * PROD_W'(LANE_HEIGHT);
  assign scaled = prod[PROD_W-1 -: LH_W];
  assign row    = ROW_W'(LH_W'(LANE_HEIGHT - 1) - scaled);

  generate
    if (DATA_WIDTH > OFFSET_BITS) begin : g_low_bits
      logic unused_low;
      assign unused_low = ^sample[DATA_WIDTH-OFFSET_BITS-1:0];
    end
  endgenerate

endmodule

// File: rtl/multichannel_sample_to_pixel_addr_translator.sv
// Pops interleaved samples and emits framebuffer word/bit per pixel; valid 3 cycles after fifo_rd_en, held until out_ready.
// No FIFO read while an output is pending; WAVE_XLAT_DECIM_EN plots only every 2**DECIM_LOG2-th frame.
module multichannel_sample_to_pixel_addr_translator
  import wave_xlat_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CHANNELS   = 2,
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int WORD_BITS      = 32,
  parameter int ADDRESS_LENGTH = 14,
  parameter int DECIM_LOG2     = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [DATA_WIDTH-1:0]             sample,
  input  logic                              fifo_almost_empty,
  output logic                              fifo_rd_en,
  input  logic                              out_ready,
  output logic [ADDRESS_LENGTH-1:0]         word_address,
  output logic [clog2(WORD_BITS)-1:0]       bit_offset,
  output logic [width_of(NUM_CHANNELS)-1:0] channel,
  output logic                              word_and_offset_valid,
  output logic                              column_wrap
);

  localparam int LANE_HEIGHT = DISPLAY_HEIGHT / NUM_CHANNELS;
  localparam int OFF_W       = clog2(WORD_BITS);
  localparam int CH_W        = width_of(NUM_CHANNELS);
  localparam int COL_W       = width_of(DISPLAY_WIDTH);
  localparam int ROW_W       = width_of(LANE_HEIGHT);
  localparam int PIX_W       = width_of(DISPLAY_WIDTH * DISPLAY_HEIGHT);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sample_q;
  logic [PIX_W-1:0]      pixel_q, pixel_d;
  logic [ROW_W-1:0]      row;
  logic [CH_W-1:0]       ch_cnt;
  logic [COL_W-1:0]      column;
  logic                  handshake, ch_last, col_last, plot, ch_step;

  sample_to_row_scaler #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_HEIGHT(LANE_HEIGHT),
    .ROW_W      (ROW_W)
  ) u_scaler (
    .sample(sample_q),
    .row   (row)
  );

  assign handshake = (state_q == OUT) && out_ready;
  assign ch_last   = (ch_cnt == CH_W'(NUM_CHANNELS - 1));
  assign col_last  = (column == COL_W'(DISPLAY_WIDTH - 1));
  assign ch_step   = handshake || ((state_q == CALC) && !plot);

`ifdef WAVE_XLAT_DECIM_EN
  logic [DECIM_LOG2-1:0] decim_cnt;

  assign plot = (decim_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      decim_cnt <= '0;
    end else if (ch_step && ch_last) begin
      decim_cnt <= decim_cnt + 1'b1;
    end
  end
`else
  localparam int unused_decim_log2 = DECIM_LOG2;

  assign plot = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_almost_empty) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = CALC;
      CALC:    state_d = plot ? OUT : IDLE;
      // Skip the idle cycle when data is waiting so a held-high out_ready sustains one sample per 4 cycles.
      OUT:     if (out_ready) state_d = fifo_almost_empty ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pixel_d = (PIX_W'(ch_cnt) * PIX_W'(LANE_HEIGHT) + PIX_W'(row)) * PIX_W'(DISPLAY_WIDTH)
                 + PIX_W'(column);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_q <= '0;
      pixel_q  <= '0;
    end else begin
      if (state_q == CAPTURE) sample_q <= sample;
      if ((state_q == CALC) && plot) pixel_q <= pixel_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ch_cnt      <= '0;
      column      <= '0;
      column_wrap <= 1'b0;
    end else begin
      column_wrap <= handshake && ch_last && col_last;
      if (ch_step) ch_cnt <= ch_last ? '0 : ch_cnt + CH_W'(1);
      if (handshake && ch_last) column <= col_last ? '0 : column + COL_W'(1);
    end
  end

  assign fifo_rd_en            = (state_q == READ);
  assign word_and_offset_valid = (state_q == OUT);
  assign word_address          = ADDRESS_LENGTH'(pixel_q >> OFF_W);
  assign bit_offset            = pixel_q[OFF_W-1:0];
  assign channel               = ch_cnt;

endmodule

// File: tb/tb_multichannel_sample_to_pixel_addr_translator.sv
// Directed bench for the default two-channel 640x480 build with hand-computed addresses.
// The bench plays the sample FIFO (data supplied the cycle after fifo_rd_en) and the framebuffer writer.
module tb_multichannel_sample_to_pixel_addr_translator;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] sample = '0;
  logic        fifo_almost_empty = 1'b1;
  logic        fifo_rd_en;
  logic        out_ready = 1'b0;
  logic [13:0] word_address;
  logic [4:0]  bit_offset;
  logic [0:0]  channel;
  logic        word_and_offset_valid;
  logic        column_wrap;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int wrap_cnt = 0;
  int wrap_at = -1;

  multichannel_sample_to_pixel_addr_translator dut (
    .clk                  (clk),
    .resetn               (resetn),
    .sample               (sample),
    .fifo_almost_empty    (fifo_almost_empty),
    .fifo_rd_en           (fifo_rd_en),
    .out_ready            (out_ready),
    .word_address         (word_address),
    .bit_offset           (bit_offset),
    .channel              (channel),
    .word_and_offset_valid(word_and_offset_valid),
    .column_wrap          (column_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready only changes just after a rising edge, so the negedge value is the one the DUT sees.
  always @(negedge clk) begin
    if (word_and_offset_valid && out_ready) hs_cnt++;
    if (column_wrap) begin
      wrap_cnt++;
      wrap_at = hs_cnt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Serves one FIFO read and returns at the falling edge where the output is valid.
  task automatic do_sample(input logic [31:0] s, output bit ok, output int t_valid);
    int n;
    ok = 1'b0;
    t_valid = 0;
    n = 0;
    while (fifo_rd_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (fifo_rd_en !== 1'b1) return;
    @(posedge clk);
    #1 sample = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (word_and_offset_valid !== 1'b1 && n < 20);
    ok = (word_and_offset_valid === 1'b1);
    t_valid = cyc;
  endtask

  task automatic test_reset();
    int rd_seen, vld_seen;
    resetn = 1'b0;
    fifo_almost_empty = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (word_and_offset_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_held: valid %0b rd_en %0b, required 0 0", word_and_offset_valid, fifo_rd_en); end
    @(posedge clk);
    #1 resetn = 1'b1;
    rd_seen = 0;
    vld_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) rd_seen++;
      if (word_and_offset_valid !== 1'b0) vld_seen++;
    end
    checks++; if (rd_seen !== 0) begin errors++; $display("FAIL idle_no_read: rd_en high %0d cycles, required 0", rd_seen); end
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL idle_no_valid: valid high %0d cycles, required 0", vld_seen); end
    checks++; if (word_address !== 14'd0) begin errors++; $display("FAIL reset_word: got %0d required 0", word_address); end
    checks++; if (bit_offset !== 5'd0) begin errors++; $display("FAIL reset_offset: got %0d required 0", bit_offset); end
    checks++; if (channel !== 1'b0) begin errors++; $display("FAIL reset_channel: got %0d required 0", channel); end
    checks++; if (column_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b required 0", column_wrap); end
  endtask

  task automatic test_first_frame();
    bit ok;
    int t0, t1;
    fifo_almost_empty = 1'b0;
    out_ready = 1'b1;
    do_sample(32'h7FFFFF00, ok, t0);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL f0_ch0_valid: got %0b required 1", ok); end
    checks++; if (word_address !== 14'd0 || bit_offset !== 5'd0 || channel !== 1'b0) begin errors++; $display("FAIL f0_ch0_addr: got word %0d off %0d ch %0d, required word 0 off 0 ch 0", word_address, bit_offset, channel); end
    do_sample(32'h80000100, ok, t1);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL f0_ch1_valid: got %0b required 1", ok); end
    checks++; if (word_address !== 14'd9580 || bit_offset !== 5'd0 || channel !== 1'b1) begin errors++; $display("FAIL f0_ch1_addr: got word %0d off %0d ch %0d, required word 9580 off 0 ch 1", word_address, bit_offset, channel); end
    checks++; if (t1 - t0 !== 4) begin errors++; $display("FAIL throughput: got %0d cycles between outputs, required 4", t1 - t0); end
  endtask

  task automatic test_mid_scale();
    bit ok;
    int t;
    do_sample(32'h00000000, ok, t);
    checks++; if (ok !== 1'b1 || word_address !== 14'd2380 || bit_offset !== 5'd1 || channel !== 1'b0) begin errors++; $display("FAIL f1_ch0_mid: got ok %0b word %0d off %0d ch %0d, required ok 1 word 2380 off 1 ch 0", ok, word_address, bit_offset, channel); end
    do_sample(32'h80000100, ok, t);
    checks++; if (ok !== 1'b1 || word_address !== 14'd9580 || bit_offset !== 5'd1 || channel !== 1'b1) begin errors++; $display("FAIL f1_ch1_neg: got ok %0b word %0d off %0d ch %0d, required ok 1 word 9580 off 1 ch 1", ok, word_address, bit_offset, channel); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int t, base, bad;
    logic [13:0] wa;
    logic [4:0]  bo;
    @(posedge clk);
    #1 out_ready = 1'b0;
    do_sample(32'h7FFFFF00, ok, t);
    checks++; if (ok !== 1'b1 || word_address !== 14'd0 || bit_offset !== 5'd2 || channel !== 1'b0) begin errors++; $display("FAIL stall_first: got ok %0b word %0d off %0d ch %0d, required ok 1 word 0 off 2 ch 0", ok, word_address, bit_offset, channel); end
    wa = word_address;
    bo = bit_offset;
    base = hs_cnt;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (word_and_offset_valid !== 1'b1 || fifo_rd_en !== 1'b0 || word_address !== wa || bit_offset !== bo || channel !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles, required 0", bad); end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (hs_cnt - base !== 1) begin errors++; $display("FAIL release_one_hs: got %0d handshakes, required 1", hs_cnt - base); end
    checks++; if (word_and_offset_valid !== 1'b0) begin errors++; $display("FAIL release_valid_drop: got %0b required 0", word_and_offset_valid); end
    do_sample(32'h80000100, ok, t);
    checks++; if (ok !== 1'b1 || word_address !== 14'd9580 || bit_offset !== 5'd2 || channel !== 1'b1) begin errors++; $display("FAIL stall_next_ch1: got ok %0b word %0d off %0d ch %0d, required ok 1 word 9580 off 2 ch 1", ok, word_address, bit_offset, channel); end
  endtask

  task automatic test_column_wrap();
    bit ok;
    int t, base_hs, base_wrap, bad;
    logic [13:0] wa_last;
    logic [4:0]  bo_last;
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    base_hs = hs_cnt;
    base_wrap = wrap_cnt;
    bad = 0;
    wa_last = '0;
    bo_last = '0;
    for (int i = 0; i < 1280; i++) begin
      do_sample(i[0] ? 32'h80000100 : 32'h7FFFFF00, ok, t);
      if (!ok) bad++;
      if (i == 1278) begin
        wa_last = word_address;
        bo_last = bit_offset;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stream_valid: %0d samples timed out, required 0", bad); end
    checks++; if (wa_last !== 14'd19 || bo_last !== 5'd31) begin errors++; $display("FAIL last_column: got word %0d off %0d, required word 19 off 31", wa_last, bo_last); end
    do_sample(32'h7FFFFF00, ok, t);
    checks++; if (wrap_cnt - base_wrap !== 1) begin errors++; $display("FAIL wrap_count: got %0d pulses, required 1", wrap_cnt - base_wrap); end
    checks++; if (wrap_at - base_hs !== 1280) begin errors++; $display("FAIL wrap_position: pulse after handshake %0d, required 1280", wrap_at - base_hs); end
    checks++; if (ok !== 1'b1 || word_address !== 14'd0 || bit_offset !== 5'd0 || channel !== 1'b0) begin errors++; $display("FAIL wrap_col0: got ok %0b word %0d off %0d ch %0d, required ok 1 word 0 off 0 ch 0", ok, word_address, bit_offset, channel); end
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    int t, n, bad;
    n = 0;
    while (fifo_rd_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL mid_calc_read: rd_en %0b, required 1", fifo_rd_en); end
    @(posedge clk);
    #1 sample = 32'h80000100;
    @(posedge clk);
    #2 resetn = 1'b0;
    fifo_almost_empty = 1'b1;
    #1;
    checks++; if (word_and_offset_valid !== 1'b0 || word_address !== 14'd0 || channel !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_calc_reset: valid %0b word %0d ch %0d rd_en %0b, required all 0", word_and_offset_valid, word_address, channel, fifo_rd_en); end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (word_and_offset_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stale_valid: valid high %0d cycles, required 0", bad); end
    fifo_almost_empty = 1'b0;
    do_sample(32'h80000100, ok, t);
    checks++; if (ok !== 1'b1 || word_address !== 14'd4780 || bit_offset !== 5'd0 || channel !== 1'b0) begin errors++; $display("FAIL after_reset_ch0: got ok %0b word %0d off %0d ch %0d, required ok 1 word 4780 off 0 ch 0", ok, word_address, bit_offset, channel); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_mid_scale();
    test_backpressure();
    test_column_wrap();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
